ntr_cmd_engine: RTL and testbench

- Parametrised NTR cartridge-bus slave engine, running entirely in the system `clk` domain.
- Oversamples `ntr_clk` and `ntr_cs1`, shifts in a `CMD_BYTES`-byte command and hands it to host logic.
- Streams a host-sized response of 32-bit words back onto the bus one byte per `ntr_clk` cycle, through a 2-entry word prefetch buffer.
- Sits between the `ppio` bus pad and the command-decode/response logic in `top`.

---
 rtl/ntr_cmd_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_ntr_cmd_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntr_cmd_engine.sv
// NTR cartridge-bus slave engine. Everything runs on the system clock:
// ntr_clk/ntr_cs1 are oversampled, a fixed-length command is shifted in,
// and a host-sized stream of response words is played back one byte per
// bus clock through a two-word prefetch buffer.
module ntr_cmd_engine #(
    parameter int          CMD_BYTES     = 8,
    parameter int          SYNC_STAGES   = 2,
    parameter int          LEN_W         = 16,
    parameter int          WORD_BYTES    = 4,
    parameter int          MSB_FIRST     = 0,
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ntr_clk,
    input  logic                      ntr_cs1,
    input  logic [7:0]                ntr_data_in,
    output logic [7:0]                ntr_data_out,
    output logic                      ntr_data_oe,
    output logic [8*CMD_BYTES-1:0]    command,
    output logic                      cmd_valid,
    input  logic                      resp_ack,
    input  logic [LEN_W-1:0]          resp_len,
    output logic                      word_req,
    input  logic                      word_valid,
    input  logic [8*WORD_BYTES-1:0]   word_data,
    output logic                      underrun,
    output logic                      busy
);

    localparam int CW = (CMD_BYTES  > 1) ? $clog2(CMD_BYTES)  : 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WW = 8*WORD_BYTES;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DECODE, S_RESP, S_DRAIN} state_e;

    // ---------------- bus synchronisers ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, sync_vld_q;
    logic                   clk_prev_q, cs_prev_q, arm_q;
    logic                   clk_s, cs_s, rise, cs_rise;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign rise    = clk_s & ~clk_prev_q;
    assign cs_rise = cs_s & ~cs_prev_q;

    // Synchronise bus clock/select; arm only once a genuine cs1-high sample has
    // been seen, so a reset with cs1 held low cannot start a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            cs_sync_q  <= '1;
            sync_vld_q <= '0;
            clk_prev_q <= 1'b1;
            cs_prev_q  <= 1'b1;
            arm_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ntr_clk};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], ntr_cs1};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            clk_prev_q <= clk_s;
            cs_prev_q  <= cs_s;
            if (sync_vld_q[SYNC_STAGES-1] && cs_s)
                arm_q <= 1'b1;
        end
    end

    // ---------------- engine state ----------------
    state_e                 state_q, state_d;
    logic [CW-1:0]          cmd_cnt_q, cmd_cnt_d;
    logic [8*CMD_BYTES-1:0] command_q, command_d;
    logic                   underrun_q, underrun_d;
    logic [LEN_W-1:0]       req_cnt_q, req_cnt_d, cons_cnt_q, cons_cnt_d;
    logic [WW-1:0]          mem_q [2];
    logic                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]             fill_q, fill_d;
    logic [BW-1:0]          bidx_q, bidx_d, sel_b;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   push, pop;
    logic [WW-1:0]          head_w;

    // A slot is offered only while words are still owed and no deselect is landing.
    assign word_req = (state_q == S_RESP) && (fill_q != 2'd2) &&
                      (req_cnt_q != '0) && !cs_rise;
    assign push     = word_req & word_valid;

    // Next-state, counters, buffer pointers and registered pad outputs.
    always_comb begin
        state_d     = state_q;
        cmd_cnt_d   = cmd_cnt_q;
        command_d   = command_q;
        underrun_d  = underrun_q;
        req_cnt_d   = req_cnt_q;
        cons_cnt_d  = cons_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        bidx_d      = bidx_q;
        pop         = 1'b0;
        head_w      = '0;
        sel_b       = '0;
        dout_d      = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (arm_q && !cs_s) begin
                    state_d    = S_CMD;
                    cmd_cnt_d  = '0;
                    underrun_d = 1'b0;
                end
            end
            S_CMD: begin
                if (rise) begin
                    command_d[{cmd_cnt_q, 3'b000} +: 8] = ntr_data_in;
                    if (cmd_cnt_q == CW'(CMD_BYTES-1))
                        state_d = S_DECODE;
                    else
                        cmd_cnt_d = cmd_cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                // Host has not answered yet: the byte the bus clocks out is junk.
                if (rise)
                    underrun_d = 1'b1;
                if (resp_ack) begin
                    req_cnt_d  = resp_len;
                    cons_cnt_d = resp_len;
                    state_d    = (resp_len == '0) ? S_DRAIN : S_RESP;
                end
            end
            S_RESP: begin
                if (rise) begin
                    if (fill_q != 2'd0) begin
                        if (bidx_q == BW'(WORD_BYTES-1)) begin
                            pop    = 1'b1;
                            bidx_d = '0;
                            if (cons_cnt_q != '0)
                                cons_cnt_d = cons_cnt_q - LEN_W'(1);
                            if (cons_cnt_q == LEN_W'(1))
                                state_d = S_DRAIN;
                        end else begin
                            bidx_d = bidx_q + BW'(1);
                        end
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            if (req_cnt_q != '0)
                req_cnt_d = req_cnt_q - LEN_W'(1);
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        fill_d = fill_q + {1'b0, push} - {1'b0, pop};

        // Deselect wins over everything; underrun is deliberately kept.
        if (cs_rise) begin
            state_d  = S_IDLE;
            fill_d   = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            bidx_d   = '0;
        end

        // Head word after this cycle's update; a word being pushed straight
        // into the head slot bypasses the buffer so it is visible at once.
        head_w = (push && (wr_ptr_q == rd_ptr_d)) ? word_data : mem_q[rd_ptr_d];
        sel_b  = (MSB_FIRST != 0) ? (BW'(WORD_BYTES-1) - bidx_d) : bidx_d;

        cmd_valid_d = (state_d == S_DECODE);
        oe_d        = (state_d == S_DECODE) || (state_d == S_RESP) || (state_d == S_DRAIN);
        case (state_d)
            S_DECODE, S_DRAIN: dout_d = UNDERRUN_BYTE;
            S_RESP:            dout_d = (fill_d != 2'd0) ? head_w[{sel_b, 3'b000} +: 8]
                                                          : UNDERRUN_BYTE;
            default:           dout_d = 8'h00;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_cnt_q   <= '0;
            command_q   <= '0;
            underrun_q  <= 1'b0;
            req_cnt_q   <= '0;
            cons_cnt_q  <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fill_q      <= 2'd0;
            bidx_q      <= '0;
            cmd_valid_q <= 1'b0;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_cnt_q   <= cmd_cnt_d;
            command_q   <= command_d;
            underrun_q  <= underrun_d;
            req_cnt_q   <= req_cnt_d;
            cons_cnt_q  <= cons_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            bidx_q      <= bidx_d;
            cmd_valid_q <= cmd_valid_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    // Prefetch storage; contents are qualified by fill_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= word_data;
    end

    assign command      = command_q;
    assign cmd_valid    = cmd_valid_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q != S_IDLE);
    assign ntr_data_out = dout_q;
    assign ntr_data_oe  = oe_q;

endmodule

// File: tb/tb_ntr_cmd_engine.sv
// Directed bench for ntr_cmd_engine: command capture, response streaming,
// underrun, deselect flush, zero-length response and mid-transfer reset.
module tb_ntr_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ntr_clk = 1'b1;
    logic        ntr_cs1 = 1'b1;
    logic [7:0]  ntr_data_in = 8'h00;
    logic [7:0]  ntr_data_out;
    logic        ntr_data_oe;
    logic [63:0] command;
    logic        cmd_valid;
    logic        resp_ack = 1'b0;
    logic [15:0] resp_len = 16'd0;
    logic        word_req;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = 32'h0;
    logic        underrun;
    logic        busy;

    int total = 0;
    int passed = 0;
    int failed = 0;

    ntr_cmd_engine dut (
        .clk(clk), .rst_n(rst_n), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
        .ntr_data_in(ntr_data_in), .ntr_data_out(ntr_data_out),
        .ntr_data_oe(ntr_data_oe), .command(command), .cmd_valid(cmd_valid),
        .resp_ack(resp_ack), .resp_len(resp_len), .word_req(word_req),
        .word_valid(word_valid), .word_data(word_data), .underrun(underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus clock: low then high, long enough to clear the synchroniser.
    task automatic pulse();
        ntr_clk = 1'b0;
        tick(4);
        ntr_clk = 1'b1;
        tick(4);
    endtask

    task automatic select();
        ntr_cs1 = 1'b0;
        tick(6);
    endtask

    task automatic deselect();
        ntr_cs1 = 1'b1;
        tick(6);
    endtask

    task automatic send_cmd(input logic [63:0] c);
        for (int i = 0; i < 8; i++) begin
            ntr_data_in = c[8*i +: 8];
            pulse();
        end
    endtask

    task automatic ack(input logic [15:0] len);
        resp_len = len;
        resp_ack = 1'b1;
        tick(1);
        resp_ack = 1'b0;
    endtask

    // Offer a word and wait (bounded) for the engine to take it.
    task automatic push_word(input string tag, input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        word_data  = w;
        word_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (word_req) begin
                tick(1);
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        word_valid = 1'b0;
        chk(tag, {63'd0, ok}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        #1 rst_n = 1'b0;
        #1;
        chk("rst_oe",    {63'd0, ntr_data_oe}, 64'd0);
        chk("rst_dout",  {56'd0, ntr_data_out}, 64'h00);
        chk("rst_cmd",   command, 64'd0);
        chk("rst_cvld",  {63'd0, cmd_valid}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_wreq",  {63'd0, word_req}, 64'd0);
        chk("rst_unr",   {63'd0, underrun}, 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // ---- 1: command capture ----
        select();
        chk("t1_busy", {63'd0, busy}, 64'd1);
        send_cmd(64'h00000000_00000090);
        chk("t1_cmd",  command, 64'h00000000_00000090);
        chk("t1_cvld", {63'd0, cmd_valid}, 64'd1);
        chk("t1_oe",   {63'd0, ntr_data_oe}, 64'd1);
        chk("t1_dout", {56'd0, ntr_data_out}, 64'hFF);

        // ---- 2: single-word response, LSB byte first ----
        ack(16'd1);
        chk("t2_cvld",  {63'd0, cmd_valid}, 64'd0);
        chk("t2_empty", {56'd0, ntr_data_out}, 64'hFF);
        push_word("t2_push", 32'h807F01E0);
        chk("t2_b0", {56'd0, ntr_data_out}, 64'hE0);
        pulse();
        chk("t2_b1", {56'd0, ntr_data_out}, 64'h01);
        pulse();
        chk("t2_b2", {56'd0, ntr_data_out}, 64'h7F);
        pulse();
        chk("t2_b3", {56'd0, ntr_data_out}, 64'h80);
        pulse();
        chk("t2_end",  {56'd0, ntr_data_out}, 64'hFF);
        chk("t2_unr",  {63'd0, underrun}, 64'd0);
        chk("t2_wreq", {63'd0, word_req}, 64'd0);

        // ---- 3: three words, host stalls on the second ----
        deselect();
        select();
        send_cmd(64'h08070605_04030201);
        chk("t3_cmd", command, 64'h08070605_04030201);
        ack(16'd3);
        push_word("t3_pushA", 32'h44332211);
        chk("t3_wreqA", {63'd0, word_req}, 64'd1);
        chk("t3_a0", {56'd0, ntr_data_out}, 64'h11);
        pulse();
        chk("t3_a1", {56'd0, ntr_data_out}, 64'h22);
        pulse();
        chk("t3_a2", {56'd0, ntr_data_out}, 64'h33);
        pulse();
        chk("t3_a3", {56'd0, ntr_data_out}, 64'h44);
        pulse();
        chk("t3_dry",     {56'd0, ntr_data_out}, 64'hFF);
        chk("t3_unr_pre", {63'd0, underrun}, 64'd0);
        pulse();
        chk("t3_stall", {56'd0, ntr_data_out}, 64'hFF);
        chk("t3_unr",   {63'd0, underrun}, 64'd1);
        tick(20);
        push_word("t3_pushB", 32'h88776655);
        chk("t3_b0", {56'd0, ntr_data_out}, 64'h55);
        push_word("t3_pushC", 32'hCCBBAA99);
        chk("t3_noreq", {63'd0, word_req}, 64'd0);
        begin
            logic [63:0] exp_bytes;
            exp_bytes = 64'hCCBBAA99_88776655;
            for (int i = 1; i < 8; i++) begin
                pulse();
                chk($sformatf("t3_byte%0d", i), {56'd0, ntr_data_out}, {56'd0, exp_bytes[8*i +: 8]});
            end
        end
        pulse();
        chk("t3_drain", {56'd0, ntr_data_out}, 64'hFF);
        chk("t3_oe",    {63'd0, ntr_data_oe}, 64'd1);
        chk("t3_wreqZ", {63'd0, word_req}, 64'd0);

        // ---- 4: deselect mid-word, then clean recapture ----
        deselect();
        chk("t4_keep_unr", {63'd0, underrun}, 64'd1);
        chk("t4_idle",     {63'd0, busy}, 64'd0);
        select();
        chk("t4_unr_clr", {63'd0, underrun}, 64'd0);
        send_cmd(64'h11111111_11111111);
        ack(16'd1);
        push_word("t4_push", 32'hDDCCBBAA);
        chk("t4_b0", {56'd0, ntr_data_out}, 64'hAA);
        pulse();
        chk("t4_b1", {56'd0, ntr_data_out}, 64'hBB);
        pulse();
        deselect();
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_oe",   {63'd0, ntr_data_oe}, 64'd0);
        chk("t4_dout", {56'd0, ntr_data_out}, 64'h00);
        chk("t4_cvld", {63'd0, cmd_valid}, 64'd0);
        select();
        send_cmd(64'h0102A0B0_C0D0E0F0);
        chk("t4_cmd2",  command, 64'h0102A0B0_C0D0E0F0);
        chk("t4_cvld2", {63'd0, cmd_valid}, 64'd1);
        ack(16'd1);
        chk("t4_flushed", {56'd0, ntr_data_out}, 64'hFF);
        chk("t4_wreq",    {63'd0, word_req}, 64'd1);

        // ---- 5: zero-length response ----
        deselect();
        select();
        send_cmd(64'h55AA55AA_55AA55AA);
        pulse();
        chk("t5_dec_unr",  {63'd0, underrun}, 64'd1);
        chk("t5_dec_cvld", {63'd0, cmd_valid}, 64'd1);
        chk("t5_dec_dout", {56'd0, ntr_data_out}, 64'hFF);
        ack(16'd0);
        chk("t5_busy", {63'd0, busy}, 64'd1);
        chk("t5_oe",   {63'd0, ntr_data_oe}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk($sformatf("t5_ff%0d", i), {56'd0, ntr_data_out}, 64'hFF);
            chk($sformatf("t5_wreq%0d", i), {63'd0, word_req}, 64'd0);
        end

        // ---- 6: asynchronous reset during response ----
        deselect();
        select();
        send_cmd(64'h0000000F_0000000E);
        ack(16'd1);
        push_word("t6_push", 32'h12345678);
        chk("t6_b0", {56'd0, ntr_data_out}, 64'h78);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_oe",   {63'd0, ntr_data_oe}, 64'd0);
        chk("t6_dout", {56'd0, ntr_data_out}, 64'h00);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_cmd",  command, 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(8);
        chk("t6_noarm", {63'd0, busy}, 64'd0);
        send_cmd(64'hA5A5A5A5_A5A5A5A5);
        chk("t6_nocap",  command, 64'd0);
        chk("t6_nocvld", {63'd0, cmd_valid}, 64'd0);
        deselect();
        select();
        send_cmd(64'hDEADBEEF_CAFEF00D);
        chk("t6_cap",  command, 64'hDEADBEEF_CAFEF00D);
        chk("t6_cvld", {63'd0, cmd_valid}, 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
